// File: rtl/tone_gen_pkg.sv
// Shared types, constants and phase arithmetic for the built-in test-tone source.
package tone_gen_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int PHASE_LEN = 48;
    localparam int IDX_W     = 6;

    typedef logic [IDX_W-1:0]           idx_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    // One quarter of a full-scale sine, sampled at 48 points per period.
    localparam sample_t Q [0:12] = '{
        16'sd0,     16'sd4277,  16'sd8481,  16'sd12539, 16'sd16384,
        16'sd19947, 16'sd23170, 16'sd25996, 16'sd28377, 16'sd30273,
        16'sd31650, 16'sd32487, 16'sd32767
    };

    // Phase step per sample; at 48 kHz this is also the tone frequency in kHz.
    localparam idx_t STEP_TABLE [8] = '{
        6'd1, 6'd2, 6'd3, 6'd4, 6'd6, 6'd8, 6'd12, 6'd16
    };

    // Advance the phase index by one step, wrapping at the period length.
    function automatic idx_t phase_advance(input idx_t idx, input idx_t step);
        logic [IDX_W:0] sum;
        sum = {1'b0, idx} + {1'b0, step};
        if (sum >= (IDX_W+1)'(PHASE_LEN)) begin
            sum = sum - (IDX_W+1)'(PHASE_LEN);
        end
        return sum[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational phase index to signed sine sample, built from a quarter-wave table.
module sine_quarter_rom
    import tone_gen_pkg::*;
(
    input  idx_t    idx,
    output sample_t sample
);

    logic [3:0] q_addr;
    logic       negate;

    // Fold the 48-point phase onto the 13-entry quarter wave and restore the sign.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        q_addr = '0;
        negate = 1'b0;
        if (idx <= 6'd12) begin
            q_addr = 4'(idx);
        end else if (idx <= 6'd24) begin
            q_addr = 4'(6'd24 - idx);
        end else if (idx <= 6'd36) begin
            q_addr = 4'(idx - 6'd24);
            negate = 1'b1;
        end else if (idx <= 6'd47) begin
            q_addr = 4'(6'd48 - idx);
            negate = 1'b1;
        end
        sample = negate ? -Q[q_addr] : Q[q_addr];
    end

endmodule

// File: rtl/test_tone_gen.sv
// Click-free sine test-tone source: one sample per DIV clocks with a one-cycle strobe,
// starting and stopping only on the zero-phase sample.
module test_tone_gen
    import tone_gen_pkg::*;
#(
    parameter int DIV = 3,
    parameter int W   = 16
) (
    input  logic                clk_144,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [2:0]          freq_sel,
    input  logic [3:0]          atten,
    output logic signed [W-1:0] tone_out,
    output logic                tone_valid,
    output logic                busy
);

    localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [SLOT_W-1:0] slot;
    logic              sample_edge;

    state_t state;
    state_t state_nxt;

    idx_t idx;
    idx_t step;
    idx_t advance;
    idx_t emit_idx;
    idx_t idx_nxt;
    idx_t step_nxt;
    logic wrap;
    logic busy_nxt;

    sample_t folded;
    sample_t shifted;

    assign sample_edge = (slot == SLOT_W'(DIV - 1));
    assign advance     = phase_advance(idx, step);
    // IDLE always emits the zero-phase sample; otherwise the phase moves on.
    assign emit_idx    = (state == IDLE) ? '0 : advance;
    assign wrap        = (emit_idx == '0);

    sine_quarter_rom u_rom (
        .idx    (emit_idx),
        .sample (folded)
    );

    assign shifted = folded >>> atten;

    // State register.
    always_ff @(posedge clk_144 or negedge reset_n) begin
        // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: transitions are evaluated on sample edges only.
    always_comb begin
        state_nxt = state;
        if (sample_edge) begin
            case (state)
                IDLE:     if (enable) state_nxt = RUN;
                RUN:      if (!enable) state_nxt = STOPPING;
                STOPPING: begin
                    if (enable) begin
                        state_nxt = RUN;
                    end else if (wrap) begin
                        state_nxt = IDLE;
                    end
                end
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Datapath next values: phase moves and step relatches only on sample edges.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        idx_nxt  = sample_edge ? emit_idx : idx;
        step_nxt = (sample_edge && wrap) ? STEP_TABLE[freq_sel] : step;
    end

    // Slot counter, phase accumulator and registered outputs.
    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            slot       <= '0;
            idx        <= '0;
            step       <= STEP_TABLE[0];
            tone_out   <= '0;
            tone_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            slot       <= sample_edge ? '0 : slot + 1'b1;
            idx        <= idx_nxt;
            step       <= step_nxt;
            tone_valid <= sample_edge;
            busy       <= busy_nxt;
            if (sample_edge) begin
                tone_out <= W'(shifted);
            end
        end
    end

endmodule

// File: tb/tb_test_tone_gen.sv
// Scoreboard bench for test_tone_gen: stimulus queues the expected sample for each
// slot, a monitor on the falling edge pops and compares on every strobe.
module tb_test_tone_gen;

    logic               clk_144 = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [2:0]         freq_sel;
    logic [3:0]         atten;
    logic signed [15:0] tone_out;
    logic               tone_valid;
    logic               busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int    value;
        bit    busy;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Full 48-point sine period, written out by hand.
    int SINE [48] = '{
             0,   4277,   8481,  12539,  16384,  19947,  23170,  25996,
         28377,  30273,  31650,  32487,  32767,  32487,  31650,  30273,
         28377,  25996,  23170,  19947,  16384,  12539,   8481,   4277,
             0,  -4277,  -8481, -12539, -16384, -19947, -23170, -25996,
        -28377, -30273, -31650, -32487, -32767, -32487, -31650, -30273,
        -28377, -25996, -23170, -19947, -16384, -12539,  -8481,  -4277
    };

    int cyc         = 0;
    int last_strobe = 0;
    bit have_last   = 1'b0;

    always #5 clk_144 = ~clk_144;

    test_tone_gen #(.DIV(3), .W(16)) dut (
        .clk_144    (clk_144),
        .reset_n    (reset_n),
        .enable     (enable),
        .freq_sel   (freq_sel),
        .atten      (atten),
        .tone_out   (tone_out),
        .tone_valid (tone_valid),
        .busy       (busy)
    );

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: strobe spacing and scoreboard comparison.
    always @(negedge clk_144) begin
        cyc++;
        if (!reset_n) begin
            have_last = 1'b0;
        end else if (tone_valid) begin
            if (have_last) check("strobe_gap", cyc - last_strobe, 3);
            have_last   = 1'b1;
            last_strobe = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got tone_out=%0d, expected no strobe", tone_out);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_out"}, 32'(tone_out), mon_e.value);
                check({mon_e.tag, "_busy"}, 32'(busy), 32'(mon_e.busy));
            end
        end
    end

    // Wait (bounded) for the falling edge on which the next strobe is visible.
    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_144);
            n++;
        end while (!tone_valid && n < 8);
        if (!tone_valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no strobe after %0d cycles, expected within 3", tag, n);
        end
    endtask

    // Drive inputs for one sample slot and queue the sample expected at its strobe.
    task automatic slot(input bit en, input logic [2:0] fs, input logic [3:0] at,
                        input int idx, input bit exp_busy, input string tag);
        exp_t e;
        enable   = en;
        freq_sel = fs;
        atten    = at;
        e.value  = SINE[idx] >>> at;
        e.busy   = exp_busy;
        e.tag    = $sformatf("%s_i%0d", tag, idx);
        sb.push_back(e);
        wait_strobe(e.tag);
    endtask

    // After reset release: first strobe must appear on the 3rd rising edge, idle zero.
    task automatic first_strobe(input string tag);
        exp_t e;
        int   n;
        e.value = 0;
        e.busy  = 1'b0;
        e.tag   = {tag, "_first"};
        sb.push_back(e);
        n = 0;
        do begin
            @(posedge clk_144);
            n++;
            #1;
        end while (!tone_valid && n < 8);
        check({tag, "_first_strobe_edge"}, n, 3);
        @(negedge clk_144);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        freq_sel = 3'd0;
        atten    = 4'd0;
        #12;
        check("rst_tone_out", 32'(tone_out), 0);
        check("rst_tone_valid", 32'(tone_valid), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk_144);
        reset_n = 1'b1;
        first_strobe("por");

        // 1 kHz full period from IDLE.
        slot(1'b1, 3'd0, 4'd0, 0, 1'b1, "start");
        for (int i = 1; i < 48; i++) slot(1'b1, 3'd0, 4'd0, i, 1'b1, "run1k");
        slot(1'b1, 3'd0, 4'd0, 0, 1'b1, "run1k_wrap");

        // Attenuation by 2, then back to 0 mid-cycle; freq_sel change ignored until idx 0.
        for (int i = 1; i <= 36; i++) slot(1'b1, 3'd0, 4'd2, i, 1'b1, "att2");
        for (int i = 37; i <= 39; i++) slot(1'b1, 3'd0, 4'd0, i, 1'b1, "att0");
        for (int i = 40; i <= 47; i++) slot(1'b1, 3'd7, 4'd0, i, 1'b1, "fs_ignored");
        slot(1'b1, 3'd7, 4'd0, 0, 1'b1, "fs_latch");

        // 16 kHz: 0, 28377, -28377 repeating; return to 1 kHz at the next zero.
        slot(1'b1, 3'd7, 4'd0, 16, 1'b1, "k16");
        slot(1'b1, 3'd7, 4'd0, 32, 1'b1, "k16");
        slot(1'b1, 3'd7, 4'd0, 0,  1'b1, "k16");
        slot(1'b1, 3'd7, 4'd0, 16, 1'b1, "k16");
        slot(1'b1, 3'd7, 4'd0, 32, 1'b1, "k16");
        slot(1'b1, 3'd0, 4'd0, 0,  1'b1, "k16_back");

        // Drop enable at idx 5: run out to idx 0, then IDLE zeros.
        for (int i = 1; i <= 4; i++) slot(1'b1, 3'd0, 4'd0, i, 1'b1, "pre_drop");
        slot(1'b0, 3'd0, 4'd0, 5, 1'b1, "drop");
        for (int i = 6; i <= 47; i++) slot(1'b0, 3'd0, 4'd0, i, 1'b1, "stopping");
        slot(1'b0, 3'd0, 4'd0, 0, 1'b0, "stop_wrap");
        repeat (3) slot(1'b0, 3'd0, 4'd0, 0, 1'b0, "idle");

        // Re-raise enable in STOPPING before idx 0, then exactly on the idx 0 edge.
        slot(1'b1, 3'd0, 4'd0, 0, 1'b1, "restart");
        for (int i = 1; i <= 3; i++) slot(1'b1, 3'd0, 4'd0, i, 1'b1, "run");
        slot(1'b0, 3'd0, 4'd0, 4, 1'b1, "dip");
        for (int i = 5; i <= 6; i++) slot(1'b0, 3'd0, 4'd0, i, 1'b1, "dip");
        slot(1'b1, 3'd0, 4'd0, 7, 1'b1, "resume");
        for (int i = 8; i <= 10; i++) slot(1'b1, 3'd0, 4'd0, i, 1'b1, "resume");
        slot(1'b0, 3'd0, 4'd0, 11, 1'b1, "stop2");
        for (int i = 12; i <= 39; i++) slot(1'b0, 3'd0, 4'd0, i, 1'b1, "stop2");
        for (int i = 40; i <= 47; i++) slot(1'b0, 3'd3, 4'd0, i, 1'b1, "stop2_fs");
        slot(1'b1, 3'd3, 4'd0, 0, 1'b1, "rerun_at_zero");
        slot(1'b1, 3'd3, 4'd0, 4,  1'b1, "k4");
        slot(1'b1, 3'd3, 4'd0, 8,  1'b1, "k4");
        slot(1'b1, 3'd3, 4'd0, 12, 1'b1, "k4");

        // Asynchronous reset between edges while the strobe is high.
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check("midrst_tone_out", 32'(tone_out), 0);
        check("midrst_tone_valid", 32'(tone_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk_144);
        reset_n = 1'b1;
        first_strobe("midrst");
        slot(1'b1, 3'd0, 4'd0, 0, 1'b1, "post_rst");
        slot(1'b1, 3'd0, 4'd0, 1, 1'b1, "post_rst");
        slot(1'b1, 3'd0, 4'd0, 2, 1'b1, "post_rst");

        enable = 1'b0;
        #1;
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
